// File: rtl/fabric_pkg.sv
// Shared constants and encodings for the arbitrated fabric memory.
package fabric_pkg;

    localparam int DEF_WIDTH  = 32;
    localparam int DEF_DEPTH  = 16;
    localparam int DEF_NPORTS = 2;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } op_e;

    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_FULL  = 1'b1;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fabric_arb_mem_if.sv
// Request/response bundle between fabric masters and the arbitrated memory.
interface fabric_arb_mem_if
    import fabric_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int NPORTS = DEF_NPORTS
) ();

    localparam int AW = $clog2(DEPTH);
    localparam int PW = idx_width(NPORTS);

    logic [NPORTS-1:0]       req_valid;
    logic [NPORTS-1:0]       req_write;
    logic [NPORTS*AW-1:0]    req_addr;
    logic [NPORTS*WIDTH-1:0] req_wdata;
    logic [NPORTS-1:0]       req_ready;
    logic                    resp_valid;
    logic                    resp_ready;
    logic [PW-1:0]           resp_port;
    logic [WIDTH-1:0]        resp_data;
    logic                    resp_err;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_port, resp_data, resp_err
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_port, resp_data, resp_err
    );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: lowest requesting index at or above the pointer wins,
// otherwise wrap to the lowest requesting index overall.
module rr_arbiter
    import fabric_pkg::*;
#(
    parameter  int N  = DEF_NPORTS,
    localparam int PW = idx_width(N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [N-1:0]  req,
    input  logic          advance,
    output logic [N-1:0]  grant,
    output logic [PW-1:0] grant_idx
);

    logic [PW-1:0] ptr_q;
    logic [PW-1:0] ptr_d;
    logic [N-1:0]  hi_req_s;
    logic [N-1:0]  pick_s;
    logic          found_s;

    // Grant selection from the priority pointer
    always_comb begin
        hi_req_s  = '0;
        grant     = '0;
        grant_idx = '0;
        found_s   = 1'b0;
        for (int i = 0; i < N; i++) begin
            hi_req_s[i] = req[i] & (PW'(i) >= ptr_q);
        end
        pick_s = (|hi_req_s) ? hi_req_s : req;
        for (int i = 0; i < N; i++) begin
            if (pick_s[i] && !found_s) begin
                found_s   = 1'b1;
                grant[i]  = 1'b1;
                grant_idx = PW'(i);
            end else begin
                found_s = found_s;
            end
        end
    end

    // Pointer moves one past the accepted port, wrapping at N-1
    always_comb begin
        if (advance) begin
            if (grant_idx == PW'(N - 1)) begin
                ptr_d = '0;
            end else begin
                ptr_d = grant_idx + PW'(1);
            end
        end else begin
            ptr_d = ptr_q;
        end
    end

    // Priority pointer register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/fabric_arb_mem.sv
// Multi-port flop-array memory behind a round-robin arbiter with a single
// registered response slot that supports one transaction per cycle.
module fabric_arb_mem
    import fabric_pkg::*;
#(
    parameter  int WIDTH  = DEF_WIDTH,
    parameter  int DEPTH  = DEF_DEPTH,
    parameter  int NPORTS = DEF_NPORTS,
    localparam int AW     = $clog2(DEPTH),
    localparam int PW     = idx_width(NPORTS)
) (
    input logic              clk,
    input logic              rst_n,
    fabric_arb_mem_if.slave  bus
);

    logic [NPORTS-1:0] grant_s;
    logic [PW-1:0]     grant_idx_s;
    logic              slot_free_s;
    logic [NPORTS-1:0] req_ready_s;
    logic              accept_s;
    logic              sel_write_s;
    logic [AW-1:0]     sel_addr_s;
    logic [WIDTH-1:0]  sel_wdata_s;
    logic              in_range_s;
    logic [WIDTH-1:0]  rdata_s;

    logic [WIDTH-1:0]  mem_q [DEPTH];
    logic [WIDTH-1:0]  mem_d [DEPTH];
    logic [0:0]        state_q;
    logic [0:0]        state_d;
    logic [PW-1:0]     resp_port_q;
    logic [PW-1:0]     resp_port_d;
    logic [WIDTH-1:0]  resp_data_q;
    logic [WIDTH-1:0]  resp_data_d;
    logic              resp_err_q;
    logic              resp_err_d;

    rr_arbiter #(.N(NPORTS)) u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (bus.req_valid),
        .advance   (accept_s),
        .grant     (grant_s),
        .grant_idx (grant_idx_s)
    );

    // Ready depends only on valids, pointer and slot state, so it never
    // looks at the payload of the requests.
    always_comb begin
        slot_free_s = (state_q == ST_EMPTY) | bus.resp_ready;
        if (slot_free_s && rst_n) begin
            req_ready_s = grant_s;
        end else begin
            req_ready_s = '0;
        end
        accept_s = |req_ready_s;
    end

    // Payload mux for the granted port and storage read
    always_comb begin
        sel_write_s = 1'b0;
        sel_addr_s  = '0;
        sel_wdata_s = '0;
        rdata_s     = '0;
        for (int i = 0; i < NPORTS; i++) begin
            if (grant_idx_s == PW'(i)) begin
                sel_write_s = (bus.req_write[i] == OP_WRITE);
                sel_addr_s  = bus.req_addr[i*AW +: AW];
                sel_wdata_s = bus.req_wdata[i*WIDTH +: WIDTH];
            end else begin
                sel_write_s = sel_write_s;
            end
        end
        in_range_s = ({1'b0, sel_addr_s} < (AW+1)'(DEPTH));
        for (int i = 0; i < DEPTH; i++) begin
            if (sel_addr_s == AW'(i)) begin
                rdata_s = mem_q[i];
            end else begin
                rdata_s = rdata_s;
            end
        end
    end

    // Storage next state: only an accepted, in-range write touches a word
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            if (accept_s && sel_write_s && in_range_s && (sel_addr_s == AW'(i))) begin
                mem_d[i] = sel_wdata_s;
            end else begin
                mem_d[i] = mem_q[i];
            end
        end
    end

    // Response slot next state and contents
    always_comb begin
        state_d     = state_q;
        resp_port_d = resp_port_q;
        resp_data_d = resp_data_q;
        resp_err_d  = resp_err_q;
        case (state_q)
            ST_EMPTY: begin
                if (accept_s) begin
                    state_d = ST_FULL;
                end else begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (accept_s) begin
                    state_d = ST_FULL;
                end else if (bus.resp_ready) begin
                    state_d = ST_EMPTY;
                end else begin
                    state_d = ST_FULL;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase
        if (accept_s) begin
            resp_port_d = grant_idx_s;
            resp_err_d  = !in_range_s;
            resp_data_d = (!sel_write_s && in_range_s) ? rdata_s : '0;
        end else begin
            resp_port_d = resp_port_q;
        end
    end

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_EMPTY;
            resp_port_q <= '0;
            resp_data_q <= '0;
            resp_err_q  <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            resp_port_q <= resp_port_d;
            resp_data_q <= resp_data_d;
            resp_err_q  <= resp_err_d;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    assign bus.req_ready  = req_ready_s;
    assign bus.resp_valid = (state_q == ST_FULL);
    assign bus.resp_port  = resp_port_q;
    assign bus.resp_data  = resp_data_q;
    assign bus.resp_err   = resp_err_q;

endmodule
